// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-stage enable/flush sequencing for load-use, branch, memory-wait and trap hazards
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TRAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       ex_memRead,
    input  logic [4:0] ex_Rd,
    input  logic       ex_br_taken,
    input  logic       me_mem_req,
    input  logic       me_mem_ready,
    input  logic       trap,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       idex_en,
    output logic       exme_en,
    output logic       mewb_en,
    output logic       ifid_fl,
    output logic       idex_fl,
    output logic       exme_fl,
    output logic       mewb_fl,
    output logic       trap_vec_sel,
    output logic       mem_fault,
    output logic [1:0] state_o
);
    localparam int WW = $clog2(MEM_TIMEOUT) + 1;
    localparam int FW = $clog2(TRAP_CYCLES) + 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
    localparam logic [FW-1:0] FLUSH_INIT = FW'(TRAP_CYCLES - 1);

    typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, TRAP_FLUSH = 2'b10} state_t;

    state_t state, state_nx;
    logic [WW-1:0] wait_cnt, wait_nx;
    logic [FW-1:0] flush_cnt, flush_nx;
    logic load_use, stall, do_trap;

    assign load_use = ex_memRead && ex_Rd != 5'd0 &&
                      ((id_use_rs1 && id_rs1 == ex_Rd) || (id_use_rs2 && id_rs2 == ex_Rd));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_nx;
            flush_cnt <= flush_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        wait_nx      = wait_cnt;
        flush_nx     = flush_cnt;
        stall        = 1'b0;
        do_trap      = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exme_en      = 1'b1;
        mewb_en      = 1'b1;
        ifid_fl      = 1'b0;
        idex_fl      = 1'b0;
        exme_fl      = 1'b0;
        mewb_fl      = 1'b0;
        trap_vec_sel = 1'b0;
        mem_fault    = 1'b0;
        state_o      = rst ? 2'b00 : state;
        case (state)
            RUN: begin
                if (trap) begin
                    do_trap = 1'b1;
                end else if (me_mem_req && !me_mem_ready) begin
                    stall    = 1'b1;
                    state_nx = MEM_WAIT;
                    wait_nx  = WW'(1);
                end else if (ex_br_taken) begin
                    ifid_fl = 1'b1;
                    idex_fl = 1'b1;
                end else if (load_use) begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    idex_fl = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (trap) begin
                    do_trap = 1'b1;
                    wait_nx = '0;
                end else if (me_mem_ready) begin
                    state_nx = RUN;
                    wait_nx  = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    do_trap   = 1'b1;
                    mem_fault = 1'b1;
                    wait_nx   = '0;
                end else begin
                    stall   = 1'b1;
                    wait_nx = (&wait_cnt) ? wait_cnt : wait_cnt + WW'(1);
                end
            end
            TRAP_FLUSH: begin
                ifid_fl = 1'b1;
                idex_fl = 1'b1;
                exme_fl = 1'b1;
                mewb_fl = 1'b1;
                if (trap) do_trap = 1'b1;
                else if (flush_cnt == '0) state_nx = RUN;
                else flush_nx = flush_cnt - FW'(1);
            end
            default: state_nx = RUN;
        endcase
        if (stall) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            exme_en = 1'b0;
            mewb_fl = 1'b1;
        end
        // trap and timeout share one entry path: vector PC, bubble every stage
        if (do_trap) begin
            trap_vec_sel = 1'b1;
            ifid_fl      = 1'b1;
            idex_fl      = 1'b1;
            exme_fl      = 1'b1;
            mewb_fl      = 1'b1;
            state_nx     = TRAP_FLUSH;
            flush_nx     = FLUSH_INIT;
        end
        if (rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b1;
            idex_en      = 1'b1;
            exme_en      = 1'b1;
            mewb_en      = 1'b1;
            ifid_fl      = 1'b1;
            idex_fl      = 1'b1;
            exme_fl      = 1'b1;
            mewb_fl      = 1'b1;
            trap_vec_sel = 1'b0;
            mem_fault    = 1'b0;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenario tasks for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_Rd;
    logic id_use_rs1, id_use_rs2, ex_memRead, ex_br_taken, me_mem_req, me_mem_ready, trap;
    logic pc_en, ifid_en, idex_en, exme_en, mewb_en;
    logic ifid_fl, idex_fl, exme_fl, mewb_fl, trap_vec_sel, mem_fault;
    logic [1:0] state_o;
    int checks = 0;
    int errors = 0;

    // {pc_en, ifid/idex/exme/mewb_en, ifid/idex/exme/mewb_fl, trap_vec_sel, mem_fault, state_o}
    localparam logic [12:0] RSTV       = 13'b0_1111_1111_0_0_00;
    localparam logic [12:0] DEF        = 13'b1_1111_0000_0_0_00;
    localparam logic [12:0] LU         = 13'b0_0111_0100_0_0_00;
    localparam logic [12:0] BR         = 13'b1_1111_1100_0_0_00;
    localparam logic [12:0] STALL_RUN  = 13'b0_0001_0001_0_0_00;
    localparam logic [12:0] STALL_W    = 13'b0_0001_0001_0_0_01;
    localparam logic [12:0] REL_W      = 13'b1_1111_0000_0_0_01;
    localparam logic [12:0] TRAP_RUN   = 13'b1_1111_1111_1_0_00;
    localparam logic [12:0] TRAP_W     = 13'b1_1111_1111_1_0_01;
    localparam logic [12:0] FAULT      = 13'b1_1111_1111_1_1_01;
    localparam logic [12:0] FLUSH      = 13'b1_1111_1111_0_0_10;
    localparam logic [12:0] FLUSH_TRAP = 13'b1_1111_1111_1_0_10;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .TRAP_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_memRead(ex_memRead), .ex_Rd(ex_Rd), .ex_br_taken(ex_br_taken),
        .me_mem_req(me_mem_req), .me_mem_ready(me_mem_ready), .trap(trap),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exme_en(exme_en), .mewb_en(mewb_en),
        .ifid_fl(ifid_fl), .idex_fl(idex_fl), .exme_fl(exme_fl), .mewb_fl(mewb_fl),
        .trap_vec_sel(trap_vec_sel), .mem_fault(mem_fault), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] obs();
        return {pc_en, ifid_en, idex_en, exme_en, mewb_en, ifid_fl, idex_fl, exme_fl, mewb_fl,
                trap_vec_sel, mem_fault, state_o};
    endfunction

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_Rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_memRead = 1'b0; ex_br_taken = 1'b0;
        me_mem_req = 1'b0; me_mem_ready = 1'b0; trap = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs() !== RSTV) begin errors++; $display("FAIL reset_out: got %b expected %b", obs(), RSTV); end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (obs() !== DEF) begin errors++; $display("FAIL post_reset: got %b expected %b", obs(), DEF); end
        tick();
    endtask

    task automatic test_load_use();
        ex_memRead = 1'b1; ex_Rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        #1;
        checks++;
        if (obs() !== LU) begin errors++; $display("FAIL load_use_rs1: got %b expected %b", obs(), LU); end
        tick();
        idle();
        #1;
        checks++;
        if (obs() !== DEF) begin errors++; $display("FAIL load_use_after: got %b expected %b", obs(), DEF); end
        ex_memRead = 1'b1; ex_Rd = 5'd9; id_rs1 = 5'd3; id_use_rs1 = 1'b1; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
        #1;
        checks++;
        if (obs() !== LU) begin errors++; $display("FAIL load_use_rs2: got %b expected %b", obs(), LU); end
        id_use_rs2 = 1'b0;
        #1;
        checks++;
        if (obs() !== DEF) begin errors++; $display("FAIL load_use_unused: got %b expected %b", obs(), DEF); end
        tick();
        idle();
    endtask

    task automatic test_no_hazard();
        ex_memRead = 1'b1; ex_Rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        #1;
        checks++;
        if (obs() !== DEF) begin errors++; $display("FAIL rd_zero: got %b expected %b", obs(), DEF); end
        ex_Rd = 5'd5; id_rs1 = 5'd5; ex_br_taken = 1'b1;
        #1;
        checks++;
        if (obs() !== BR) begin errors++; $display("FAIL branch_over_lu: got %b expected %b", obs(), BR); end
        idle();
        me_mem_req = 1'b1; me_mem_ready = 1'b1;
        #1;
        checks++;
        if (obs() !== DEF) begin errors++; $display("FAIL mem_single: got %b expected %b", obs(), DEF); end
        tick();
        idle();
    endtask

    task automatic test_mem_wait();
        me_mem_req = 1'b1;
        #1;
        checks++;
        if (obs() !== STALL_RUN) begin errors++; $display("FAIL mem_enter: got %b expected %b", obs(), STALL_RUN); end
        tick();
        for (int i = 0; i < 3; i++) begin
            ex_br_taken = (i == 0);
            ex_memRead = (i == 1); ex_Rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
            #1;
            checks++;
            if (obs() !== STALL_W) begin errors++; $display("FAIL mem_stall%0d: got %b expected %b", i, obs(), STALL_W); end
            tick();
        end
        idle();
        me_mem_req = 1'b1; me_mem_ready = 1'b1;
        #1;
        checks++;
        if (obs() !== REL_W) begin errors++; $display("FAIL mem_release: got %b expected %b", obs(), REL_W); end
        tick();
        idle();
        #1;
        checks++;
        if (obs() !== DEF) begin errors++; $display("FAIL mem_back_run: got %b expected %b", obs(), DEF); end
        tick();
    endtask

    task automatic test_mem_timeout();
        me_mem_req = 1'b1;
        #1;
        checks++;
        if (obs() !== STALL_RUN) begin errors++; $display("FAIL to_enter: got %b expected %b", obs(), STALL_RUN); end
        tick();
        for (int i = 1; i < 15; i++) begin
            checks++;
            if (obs() !== STALL_W) begin errors++; $display("FAIL to_stall%0d: got %b expected %b", i, obs(), STALL_W); end
            tick();
        end
        checks++;
        if (obs() !== FAULT) begin errors++; $display("FAIL to_fault: got %b expected %b", obs(), FAULT); end
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (obs() !== FLUSH) begin errors++; $display("FAIL to_flush%0d: got %b expected %b", i, obs(), FLUSH); end
            tick();
        end
        checks++;
        if (obs() !== DEF) begin errors++; $display("FAIL to_back_run: got %b expected %b", obs(), DEF); end
        tick();
    endtask

    task automatic test_trap_in_wait();
        me_mem_req = 1'b1;
        tick();
        #1;
        checks++;
        if (obs() !== STALL_W) begin errors++; $display("FAIL tw_stall: got %b expected %b", obs(), STALL_W); end
        trap = 1'b1; me_mem_ready = 1'b1;
        #1;
        checks++;
        if (obs() !== TRAP_W) begin errors++; $display("FAIL tw_trap: got %b expected %b", obs(), TRAP_W); end
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (obs() !== FLUSH) begin errors++; $display("FAIL tw_flush%0d: got %b expected %b", i, obs(), FLUSH); end
            tick();
        end
        checks++;
        if (obs() !== DEF) begin errors++; $display("FAIL tw_back_run: got %b expected %b", obs(), DEF); end
        tick();
    endtask

    task automatic test_back_to_back();
        trap = 1'b1; me_mem_req = 1'b1;
        #1;
        checks++;
        if (obs() !== TRAP_RUN) begin errors++; $display("FAIL bb_trap: got %b expected %b", obs(), TRAP_RUN); end
        tick();
        idle();
        #1;
        checks++;
        if (obs() !== FLUSH) begin errors++; $display("FAIL bb_flush_a: got %b expected %b", obs(), FLUSH); end
        tick();
        trap = 1'b1;
        #1;
        checks++;
        if (obs() !== FLUSH_TRAP) begin errors++; $display("FAIL bb_reentry: got %b expected %b", obs(), FLUSH_TRAP); end
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (obs() !== FLUSH) begin errors++; $display("FAIL bb_flush%0d: got %b expected %b", i, obs(), FLUSH); end
            tick();
        end
        checks++;
        if (obs() !== DEF) begin errors++; $display("FAIL bb_back_run: got %b expected %b", obs(), DEF); end
        tick();
    endtask

    task automatic test_rst_in_flush();
        trap = 1'b1;
        tick();
        idle();
        #1;
        checks++;
        if (obs() !== FLUSH) begin errors++; $display("FAIL rf_flush: got %b expected %b", obs(), FLUSH); end
        rst = 1'b1;
        #1;
        checks++;
        if (obs() !== RSTV) begin errors++; $display("FAIL rf_reset: got %b expected %b", obs(), RSTV); end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (obs() !== DEF) begin errors++; $display("FAIL rf_run: got %b expected %b", obs(), DEF); end
        tick();
        checks++;
        if (obs() !== DEF) begin errors++; $display("FAIL rf_run2: got %b expected %b", obs(), DEF); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_mem_wait();
        test_mem_timeout();
        test_trap_in_wait();
        test_back_to_back();
        test_rst_in_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
